// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared definitions for the dcache refill controller.
//   state_t    : controller FSM state encoding
//   *_W_DEF    : default widths used by the interface and top-level parameters
package dcache_refill_ctrl_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_MREQ   = 2'd2,
    ST_MWAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_refill_ctrl_if.sv
// Bus bundle between the dcache refill controller and its neighbours.
//   cpu_*   : MEM-stage request / response handshake
//   cache_* : combinational read port and write port of the dcache array
//   mem_*   : SRAM-like req/addr_ok/data_ok bus to the memory bridge
// master = controller view, slave = environment (CPU, array, bridge) view.
interface dcache_refill_ctrl_if
  import dcache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic                cpu_req;
  logic                cpu_wr;
  logic                cpu_uncached;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [DATA_W/8-1:0] cpu_wstrb;
  logic [DATA_W-1:0]   cpu_wdata;
  logic                cpu_addr_ok;
  logic                cpu_data_ok;
  logic [DATA_W-1:0]   cpu_rdata;

  logic [ADDR_W-1:0]   cache_raddr;
  logic                cache_hit;
  logic [DATA_W-1:0]   cache_rdata;
  logic                cache_wen;
  logic [ADDR_W-1:0]   cache_waddr;
  logic [DATA_W-1:0]   cache_wdata;

  logic                mem_req;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_addr_ok;
  logic                mem_data_ok;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    input  cpu_req, cpu_wr, cpu_uncached, cpu_addr, cpu_wstrb, cpu_wdata,
    output cpu_addr_ok, cpu_data_ok, cpu_rdata,
    output cache_raddr, cache_wen, cache_waddr, cache_wdata,
    input  cache_hit, cache_rdata,
    output mem_req, mem_wr, mem_addr, mem_wstrb, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    output cpu_req, cpu_wr, cpu_uncached, cpu_addr, cpu_wstrb, cpu_wdata,
    input  cpu_addr_ok, cpu_data_ok, cpu_rdata,
    input  cache_raddr, cache_wen, cache_waddr, cache_wdata,
    output cache_hit, cache_rdata,
    input  mem_req, mem_wr, mem_addr, mem_wstrb, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/dcache_refill_ctrl_wmerge.sv
// Combinational byte-strobe merge used for store hits.
//   old_word : current array word
//   new_word : store data
//   strb     : byte enables, 1 = take the byte from new_word
//   word     : merged result
module dcache_refill_ctrl_wmerge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0]   word
);

  always_comb begin
    word = old_word;
    for (int i = 0; i < DATA_W/8; i++) begin
      if (strb[i]) word[i*8 +: 8] = new_word[i*8 +: 8];
    end
  end

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Dcache refill controller: one request outstanding, write-through,
// load-allocate, store-no-allocate. Looks requests up in the array,
// refills on load miss and forwards misses/stores/uncached accesses to memory.
//   clk, resetn         : clock and synchronous active-low reset
//   bus (master)        : cpu / cache array / memory handshakes
//   perf_hit, perf_miss : saturating cached-load hit and miss counters
//
// state     | meaning
// ST_IDLE   | ready, cpu_addr_ok=1, latch next request
// ST_LOOKUP | array lookup of latched address; hit returns, miss/store go on
// ST_MREQ   | mem_req held with latched fields until mem_addr_ok
// ST_MWAIT  | wait mem_data_ok, answer cpu, refill on cached load
module dcache_refill_ctrl
  import dcache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  dcache_refill_ctrl_if.master    bus,
  output logic [CNT_W-1:0]        perf_hit,
  output logic [CNT_W-1:0]        perf_miss
);

  state_t              state, state_nxt;
  logic                req_wr;
  logic                req_uncached;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W/8-1:0] req_wstrb;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W-1:0]   merged;
  logic                hit_inc;
  logic                miss_inc;

  dcache_refill_ctrl_wmerge #(.DATA_W(DATA_W)) u_wmerge (
    .old_word (bus.cache_rdata),
    .new_word (req_wdata),
    .strb     (req_wstrb),
    .word     (merged)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      req_wr       <= 1'b0;
      req_uncached <= 1'b0;
      req_addr     <= '0;
      req_wstrb    <= '0;
      req_wdata    <= '0;
      perf_hit     <= '0;
      perf_miss    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && bus.cpu_req) begin
        req_wr       <= bus.cpu_wr;
        req_uncached <= bus.cpu_uncached;
        req_addr     <= bus.cpu_addr;
        req_wstrb    <= bus.cpu_wstrb;
        req_wdata    <= bus.cpu_wdata;
      end
      if (hit_inc && perf_hit != '1)   perf_hit  <= perf_hit + CNT_W'(1);
      if (miss_inc && perf_miss != '1) perf_miss <= perf_miss + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt       = state;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    bus.cpu_addr_ok = 1'b0;
    bus.cpu_data_ok = 1'b0;
    bus.cpu_rdata   = '0;
    bus.cache_raddr = '0;
    bus.cache_wen   = 1'b0;
    bus.cache_waddr = '0;
    bus.cache_wdata = '0;
    bus.mem_req     = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wstrb   = '0;
    bus.mem_wdata   = '0;

    case (state)
      ST_IDLE: begin
        bus.cpu_addr_ok = 1'b1;
        if (bus.cpu_req) state_nxt = bus.cpu_uncached ? ST_MREQ : ST_LOOKUP;
      end

      ST_LOOKUP: begin
        bus.cache_raddr = req_addr;
        if (req_wr) begin
          // write-through: update a hit line, always forward the store
          if (bus.cache_hit) begin
            bus.cache_wen   = 1'b1;
            bus.cache_waddr = req_addr;
            bus.cache_wdata = merged;
          end
          state_nxt = ST_MREQ;
        end else if (bus.cache_hit) begin
          bus.cpu_data_ok = 1'b1;
          bus.cpu_rdata   = bus.cache_rdata;
          hit_inc         = 1'b1;
          state_nxt       = ST_IDLE;
        end else begin
          miss_inc  = 1'b1;
          state_nxt = ST_MREQ;
        end
      end

      ST_MREQ: begin
        bus.mem_req   = 1'b1;
        bus.mem_wr    = req_wr;
        bus.mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
        bus.mem_wstrb = req_wr ? req_wstrb : '0;
        bus.mem_wdata = req_wdata;
        if (bus.mem_addr_ok) state_nxt = ST_MWAIT;
      end

      ST_MWAIT: begin
        if (bus.mem_data_ok) begin
          bus.cpu_data_ok = 1'b1;
          if (!req_wr) begin
            bus.cpu_rdata = bus.mem_rdata;
            // refill in the same cycle the data is returned to the cpu
            if (!req_uncached) begin
              bus.cache_wen   = 1'b1;
              bus.cache_waddr = req_addr;
              bus.cache_wdata = bus.mem_rdata;
            end
          end
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
